// File: rtl/can_tx_mailbox_sched_pkg.sv
// Shared types for the CAN transmit mailbox scheduler: FSM states, completion
// codes and the completion-pulse priority resolver.
package can_tx_pkg;

  localparam int ID_W = 11;

  typedef enum logic [1:0] {IDLE, ARB, LOAD, BUSY} sched_state_e;

  typedef enum logic [1:0] {CMP_NONE, CMP_OK, CMP_ERR, CMP_LOST} cmp_e;

  // Success outranks error, error outranks arbitration loss.
  function automatic cmp_e cmp_resolve(input logic ok, input logic err, input logic lost);
    cmp_e res;
    if (ok) begin
      res = CMP_OK;
    end else if (err) begin
      res = CMP_ERR;
    end else if (lost) begin
      res = CMP_LOST;
    end else begin
      res = CMP_NONE;
    end
    return res;
  endfunction

endpackage

// File: rtl/can_tx_mailbox_sched_if.sv
// Host-mailbox and frame-generator signal bundle of the transmit scheduler.
interface can_tx_mailbox_sched_if #(
  parameter int NUM_MB = 3,
  parameter int ID_W   = 11,
  parameter int SEL_W  = $clog2(NUM_MB)
) ();
  logic [NUM_MB-1:0]      mb_set;
  logic [NUM_MB-1:0]      mb_abort;
  logic [NUM_MB*ID_W-1:0] mb_id;
  logic                   fg_ready;
  logic                   frame_gen_intl;
  logic                   fg_arb_lost;
  logic                   fg_error;
  logic                   tx_start;
  logic [SEL_W-1:0]       tx_sel;
  logic                   tx_buff_busy;
  logic [NUM_MB-1:0]      mb_pending;
  logic [NUM_MB-1:0]      mb_ack;
  logic [NUM_MB-1:0]      mb_abort_ack;
  logic [NUM_MB-1:0]      mb_fail;

  modport master (
    output mb_set, mb_abort, mb_id, fg_ready, frame_gen_intl, fg_arb_lost, fg_error,
    input  tx_start, tx_sel, tx_buff_busy, mb_pending, mb_ack, mb_abort_ack, mb_fail
  );

  modport slave (
    input  mb_set, mb_abort, mb_id, fg_ready, frame_gen_intl, fg_arb_lost, fg_error,
    output tx_start, tx_sel, tx_buff_busy, mb_pending, mb_ack, mb_abort_ack, mb_fail
  );
endinterface

// File: rtl/can_tx_mailbox_sched_prio_sel.sv
// Combinational winner picker: lowest identifier among pending mailboxes,
// ties resolved towards the lowest mailbox index.
module can_id_prio_sel #(
  parameter int NUM_MB = 3,
  parameter int ID_W   = 11,
  parameter int SEL_W  = $clog2(NUM_MB)
) (
  input  logic [NUM_MB-1:0]      pend,
  input  logic [NUM_MB*ID_W-1:0] ids,
  output logic [SEL_W-1:0]       win_idx,
  output logic                   win_valid
);
  logic [ID_W-1:0] best_id_s;
  logic [ID_W-1:0] id_s;
  logic            take_s;

  // Strict less-than keeps the earlier (lower-index) mailbox on equal IDs.
  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    best_id_s = '0;
    id_s      = '0;
    take_s    = 1'b0;
    for (int i = 0; i < NUM_MB; i++) begin
      id_s      = ids[i*ID_W +: ID_W];
      take_s    = pend[i] && (!win_valid || (id_s < best_id_s));
      win_idx   = take_s ? SEL_W'(i) : win_idx;
      best_id_s = take_s ? id_s : best_id_s;
      win_valid = win_valid | take_s;
    end
  end
endmodule

// File: rtl/can_tx_mailbox_sched.sv
// CAN transmit mailbox scheduler: arbitrates pending mailboxes by identifier,
// hands the winner to the frame generator and retires, retries or drops it.
module can_tx_mailbox_sched #(
  parameter int NUM_MB    = 3,
  parameter int ID_W      = 11,
  parameter int MAX_RETRY = 4,
  parameter int SEL_W     = $clog2(NUM_MB)
) (
  input logic                   clk,
  input logic                   rst,
  can_tx_mailbox_sched_if.slave bus
);
  import can_tx_pkg::*;

  localparam int CNT_W = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  sched_state_e      state_r, state_s;
  logic [SEL_W-1:0]  tx_sel_r, tx_sel_s;
  logic [NUM_MB-1:0] pending_r, pending_s;
  logic [CNT_W-1:0]  cnt_r [NUM_MB];
  logic [CNT_W-1:0]  cnt_s [NUM_MB];
  logic [NUM_MB-1:0] ack_r, ack_s, abort_ack_r, abort_ack_s, fail_r, fail_s;
  logic              tx_start_r, busy_r, abort_lat_r, abort_lat_s;

  logic [NUM_MB-1:0] abort_eff_s, arb_pend_s, sel_hot_s, retire_s;
  logic [SEL_W-1:0]  win_idx_s;
  logic              win_valid_s, active_s, hit_abort_s, set_active_s;
  logic              done_s, ok_s, drop_s, fail_now_s, retry_s;
  logic [CNT_W-1:0]  cur_cnt_s, inc_s;
  cmp_e              cmp_s;

  // An abort only counts for a pending mailbox not being re-set that cycle.
  assign abort_eff_s = bus.mb_abort & ~bus.mb_set & pending_r;
  assign arb_pend_s  = pending_r & ~abort_eff_s;

  can_id_prio_sel #(.NUM_MB(NUM_MB), .ID_W(ID_W), .SEL_W(SEL_W)) u_prio_sel (
    .pend      (arb_pend_s),
    .ids       (bus.mb_id),
    .win_idx   (win_idx_s),
    .win_valid (win_valid_s)
  );

  // Next-state, pending/counter update and completion decode.
  always_comb begin
    sel_hot_s = '0;
    cur_cnt_s = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      sel_hot_s[i] = (tx_sel_r == SEL_W'(i));
      cur_cnt_s    = cur_cnt_s | (sel_hot_s[i] ? cnt_r[i] : '0);
    end
    inc_s    = (cur_cnt_s == CNT_SAT) ? cur_cnt_s : cur_cnt_s + CNT_W'(1);
    active_s = (state_r == LOAD) || (state_r == BUSY);
    cmp_s    = (state_r == BUSY) ? cmp_resolve(bus.frame_gen_intl, bus.fg_error, bus.fg_arb_lost)
                                 : CMP_NONE;

    // The frame in flight cannot be stopped, so an abort of it is only remembered.
    hit_abort_s  = abort_lat_r || (active_s && (|(abort_eff_s & sel_hot_s)));
    set_active_s = active_s && (|(bus.mb_set & sel_hot_s));
    done_s       = (cmp_s != CMP_NONE);
    ok_s         = (cmp_s == CMP_OK);
    drop_s       = done_s && !ok_s && hit_abort_s;
    fail_now_s   = done_s && !ok_s && !hit_abort_s && (MAX_RETRY != 0) && (inc_s >= CNT_LIM);
    retry_s      = done_s && !ok_s && !hit_abort_s && !fail_now_s;

    ack_s       = ok_s ? sel_hot_s : '0;
    fail_s      = fail_now_s ? sel_hot_s : '0;
    abort_ack_s = (abort_eff_s & ~(active_s ? sel_hot_s : '0)) | (drop_s ? sel_hot_s : '0);
    retire_s    = ack_s | fail_s | abort_ack_s;

    for (int i = 0; i < NUM_MB; i++) begin
      pending_s[i] = (pending_r[i] & ~retire_s[i]) | bus.mb_set[i];
      cnt_s[i]     = (bus.mb_set[i] || retire_s[i]) ? '0 :
                     ((retry_s && sel_hot_s[i]) ? inc_s : cnt_r[i]);
    end

    abort_lat_s = active_s && !done_s && hit_abort_s && !set_active_s;
    tx_sel_s    = tx_sel_r;
    case (state_r)
      IDLE: state_s = ((|pending_r) && bus.fg_ready) ? ARB : IDLE;
      ARB: begin
        state_s  = win_valid_s ? LOAD : IDLE;
        tx_sel_s = win_valid_s ? win_idx_s : tx_sel_r;
      end
      LOAD:    state_s = BUSY;
      BUSY:    state_s = done_s ? IDLE : BUSY;
      default: state_s = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      tx_sel_r    <= '0;
      pending_r   <= '0;
      ack_r       <= '0;
      abort_ack_r <= '0;
      fail_r      <= '0;
      tx_start_r  <= 1'b0;
      busy_r      <= 1'b0;
      abort_lat_r <= 1'b0;
      for (int i = 0; i < NUM_MB; i++) cnt_r[i] <= '0;
    end else begin
      state_r     <= state_s;
      tx_sel_r    <= tx_sel_s;
      pending_r   <= pending_s;
      ack_r       <= ack_s;
      abort_ack_r <= abort_ack_s;
      fail_r      <= fail_s;
      tx_start_r  <= (state_s == LOAD);
      busy_r      <= (state_s == LOAD) || (state_s == BUSY);
      abort_lat_r <= abort_lat_s;
      for (int i = 0; i < NUM_MB; i++) cnt_r[i] <= cnt_s[i];
    end
  end

  assign bus.tx_start     = tx_start_r;
  assign bus.tx_sel       = tx_sel_r;
  assign bus.tx_buff_busy = busy_r;
  assign bus.mb_pending   = pending_r;
  assign bus.mb_ack       = ack_r;
  assign bus.mb_abort_ack = abort_ack_r;
  assign bus.mb_fail      = fail_r;
endmodule

// File: tb/tb_can_tx_mailbox_sched.sv
// Directed scoreboard bench for can_tx_mailbox_sched: stimulus pushes the
// expected pulses with their cycle, a negedge monitor pops and compares.
module tb_can_tx_mailbox_sched;
  localparam int NUM_MB = 3;
  localparam int ID_W   = 11;

  localparam int EV_START = 0;
  localparam int EV_ACK   = 1;
  localparam int EV_ABORT = 2;
  localparam int EV_FAIL  = 3;

  typedef struct {
    int kind;
    int data;
    int cyc;
  } ev_t;

  logic  clk;
  logic  rst;
  int    cyc;
  int    vectors;
  int    miscompares;
  ev_t   exp_q[$];
  string kname [4] = '{"start", "ack", "abort_ack", "fail"};

  can_tx_mailbox_sched_if #(.NUM_MB(NUM_MB), .ID_W(ID_W)) bus ();

  can_tx_mailbox_sched #(.NUM_MB(NUM_MB), .ID_W(ID_W), .MAX_RETRY(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push_ev(input int k, input int d, input int c);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic pulse_set(input logic [NUM_MB-1:0] v);
    bus.mb_set = v;
    tick();
    bus.mb_set = '0;
  endtask

  task automatic pulse_abort(input logic [NUM_MB-1:0] v);
    bus.mb_abort = v;
    tick();
    bus.mb_abort = '0;
  endtask

  task automatic pulse_cmp(input logic ok, input logic err, input logic lost);
    bus.frame_gen_intl = ok;
    bus.fg_error       = err;
    bus.fg_arb_lost    = lost;
    tick();
    bus.frame_gen_intl = 1'b0;
    bus.fg_error       = 1'b0;
    bus.fg_arb_lost    = 1'b0;
  endtask

  task automatic check_ev(input int k, input int d);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_%s: got data=%0d at cycle %0d, required no event", kname[k], d, cyc);
    end else begin
      e = exp_q.pop_front();
      if ((e.kind != k) || (e.data != d) || (e.cyc != cyc)) begin
        miscompares++;
        $display("FAIL %s: got %s data=%0d cycle=%0d, required %s data=%0d cycle=%0d",
                 kname[e.kind], kname[k], d, cyc, kname[e.kind], e.data, e.cyc);
      end
    end
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_start)      check_ev(EV_START, int'(bus.tx_sel));
      if (|bus.mb_ack)       check_ev(EV_ACK,   int'(bus.mb_ack));
      if (|bus.mb_abort_ack) check_ev(EV_ABORT, int'(bus.mb_abort_ack));
      if (|bus.mb_fail)      check_ev(EV_FAIL,  int'(bus.mb_fail));
    end
  end

  initial begin
    vectors            = 0;
    miscompares        = 0;
    rst                = 1'b1;
    bus.mb_set         = '0;
    bus.mb_abort       = '0;
    bus.mb_id          = {11'h100, 11'h100, 11'h123};
    bus.fg_ready       = 1'b1;
    bus.frame_gen_intl = 1'b0;
    bus.fg_arb_lost    = 1'b0;
    bus.fg_error       = 1'b0;
    wait_to(3);
    chk("rst_tx_start", int'(bus.tx_start), 0);
    chk("rst_busy", int'(bus.tx_buff_busy), 0);
    chk("rst_pending", int'(bus.mb_pending), 0);
    chk("rst_pulses", int'({bus.mb_ack, bus.mb_abort_ack, bus.mb_fail}), 0);
    chk("rst_tx_sel", int'(bus.tx_sel), 0);
    rst = 1'b0;

    // Single mailbox latency and completion.
    wait_to(10);
    push_ev(EV_START, 0, 13);
    pulse_set(3'b001);
    wait_to(20);
    chk("busy_in_flight", int'(bus.tx_buff_busy), 1);
    wait_to(30);
    push_ev(EV_ACK, 1, 31);
    pulse_cmp(1'b1, 1'b0, 1'b0);
    chk("busy_after_ack", int'(bus.tx_buff_busy), 0);
    chk("pending_after_ack", int'(bus.mb_pending), 0);

    // Priority: mb1/mb2 share 0x100, mb0 is 0x200 -> order 1, 2, 0.
    bus.mb_id = {11'h100, 11'h100, 11'h200};
    wait_to(40);
    push_ev(EV_START, 1, 43);
    pulse_set(3'b111);
    wait_to(46);
    push_ev(EV_ACK, 2, 47);
    push_ev(EV_START, 2, 49);
    pulse_cmp(1'b1, 1'b0, 1'b0);
    wait_to(52);
    push_ev(EV_ACK, 4, 53);
    push_ev(EV_START, 0, 55);
    pulse_cmp(1'b1, 1'b0, 1'b0);
    wait_to(58);
    push_ev(EV_ACK, 1, 59);
    pulse_cmp(1'b1, 1'b1, 1'b1);

    // Retry limit: four losses give four starts then fail.
    bus.mb_id = {11'h100, 11'h100, 11'h123};
    wait_to(70);
    push_ev(EV_START, 0, 73);
    pulse_set(3'b001);
    for (int k = 0; k < 4; k++) begin
      wait_to(76 + 6 * k);
      if (k < 3) push_ev(EV_START, 0, 79 + 6 * k);
      else       push_ev(EV_FAIL, 1, 77 + 6 * k);
      pulse_cmp(1'b0, 1'b0, 1'b1);
    end
    wait_to(100);
    chk("pending_after_fail", int'(bus.mb_pending), 0);

    // Preemption after arbitration loss.
    bus.mb_id = {11'h050, 11'h100, 11'h300};
    wait_to(110);
    push_ev(EV_START, 0, 113);
    pulse_set(3'b001);
    wait_to(114);
    pulse_set(3'b100);
    wait_to(116);
    push_ev(EV_START, 2, 119);
    pulse_cmp(1'b0, 1'b0, 1'b1);
    wait_to(122);
    push_ev(EV_ACK, 4, 123);
    push_ev(EV_START, 0, 125);
    pulse_cmp(1'b1, 1'b0, 1'b0);
    wait_to(128);
    push_ev(EV_ACK, 1, 129);
    pulse_cmp(1'b1, 1'b0, 1'b0);

    // Abort of a non-active pending mailbox.
    bus.mb_id = {11'h050, 11'h400, 11'h300};
    wait_to(140);
    push_ev(EV_START, 0, 143);
    pulse_set(3'b011);
    wait_to(145);
    push_ev(EV_ABORT, 2, 146);
    pulse_abort(3'b010);
    wait_to(147);
    push_ev(EV_ACK, 1, 148);
    pulse_cmp(1'b1, 1'b0, 1'b0);

    // Abort of the active mailbox, frame then succeeds.
    wait_to(160);
    push_ev(EV_START, 0, 163);
    pulse_set(3'b001);
    wait_to(164);
    pulse_abort(3'b001);
    wait_to(166);
    push_ev(EV_ACK, 1, 167);
    pulse_cmp(1'b1, 1'b0, 1'b0);
    wait_to(172);
    chk("pending_abort_ok", int'(bus.mb_pending), 0);

    // Abort of the active mailbox during LOAD, frame then errors.
    wait_to(180);
    push_ev(EV_START, 0, 183);
    pulse_set(3'b001);
    wait_to(183);
    pulse_abort(3'b001);
    wait_to(186);
    push_ev(EV_ABORT, 1, 187);
    pulse_cmp(1'b0, 1'b1, 1'b0);
    wait_to(195);
    chk("pending_abort_err", int'(bus.mb_pending), 0);

    // Asynchronous reset in the middle of a BUSY cycle.
    wait_to(200);
    push_ev(EV_START, 0, 203);
    pulse_set(3'b001);
    wait_to(205);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_busy_async", int'(bus.tx_buff_busy), 0);
    chk("rst_pending_async", int'(bus.mb_pending), 0);
    tick();
    rst = 1'b0;
    wait_to(215);
    chk("post_rst_pending", int'(bus.mb_pending), 0);
    chk("post_rst_busy", int'(bus.tx_buff_busy), 0);
    push_ev(EV_START, 1, 218);
    pulse_set(3'b010);
    wait_to(221);
    push_ev(EV_ACK, 2, 222);
    pulse_cmp(1'b1, 1'b0, 1'b0);

    wait_to(230);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/can_tx_mailbox_sched.md
Name: can_tx_mailbox_sched

Overview:
- Scheduler between NUM_MB host-written CAN transmit mailboxes and the single frame generator / transmit buffer datapath.
- Holds a pending flag per mailbox and picks the highest-priority pending frame (lowest 11-bit identifier; ties go to the lowest index).
- Hands the winner to the frame generator with a start/busy handshake, retires it on completion, and re-arbitrates on arbitration loss or error with a bounded retry count.
- Drives tx_buff_busy, which the transmit-buffer monitor samples.

Parameters:
NUM_MB, 3, number of mailboxes (2..8)
ID_W, 11, identifier width (standard CAN)
MAX_RETRY, 4, failed attempts per mailbox before giving up; 0 = unlimited
SEL_W, $clog2(NUM_MB), width of the mailbox index

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
mb_set  in  NUM_MB  per-mailbox one-cycle pulse: frame loaded, request transmit
mb_abort  in  NUM_MB  per-mailbox one-cycle pulse: cancel request
mb_id  in  NUM_MB*ID_W  flattened identifiers, mailbox i at [i*ID_W +: ID_W], stable while pending
fg_ready  in  1  frame generator idle and able to accept a frame
frame_gen_intl  in  1  pulse: frame transmitted successfully
fg_arb_lost  in  1  pulse: bus arbitration lost
fg_error  in  1  pulse: bus/protocol error, frame aborted
tx_start  out  1  one-cycle pulse: load mailbox tx_sel into the transmit buffer
tx_sel  out  SEL_W  index of the active mailbox
tx_buff_busy  out  1  high from tx_start until the cycle after completion
mb_pending  out  NUM_MB  internal pending flags
mb_ack  out  NUM_MB  pulse: mailbox sent
mb_abort_ack  out  NUM_MB  pulse: mailbox cancelled
mb_fail  out  NUM_MB  pulse: retry limit reached, mailbox dropped

Behaviour:
- Reset values: all outputs 0, state IDLE, pending flags and retry counters 0. Reset mid-frame returns to IDLE immediately with no ack, abort_ack or fail pulse; the frame generator shares rst.
- Pending flag i:
  - set by mb_set[i];
  - cleared by ack, abort_ack or fail of mailbox i;
  - set and clear in the same cycle: set wins, counter cleared.
- State machine, all outputs registered:
  - IDLE: go to ARB when any pending flag is set and fg_ready=1.
  - ARB: the winner among pending flags is registered into tx_sel; go to LOAD. If no flag is pending (all aborted), go to IDLE.
  - LOAD: tx_start=1 and tx_buff_busy=1; go to BUSY.
  - BUSY: hold tx_buff_busy=1 and wait for a completion pulse.
    - frame_gen_intl: pulse mb_ack[tx_sel], clear pending and counter.
    - fg_arb_lost or fg_error: increment the counter of tx_sel. If MAX_RETRY!=0 and the counter reaches MAX_RETRY, pulse mb_fail and clear pending; otherwise pending stays set.
    - After any completion, tx_buff_busy drops the next cycle; go to IDLE.
  - Completion pulses in any state other than BUSY are ignored.
- Simultaneous completion pulses resolve with priority frame_gen_intl > fg_error > fg_arb_lost; only one is acted on.
- Latency: mb_set high in cycle N with the scheduler IDLE and fg_ready=1 gives tx_start high in cycle N+3.
- Re-arbitration after a loss or error re-evaluates all pending flags, so a newly set lower-ID mailbox preempts the retried one.
- Abort of a non-active mailbox: mb_abort_ack pulses the next cycle and pending is cleared.
- Abort of the active mailbox (LOAD or BUSY) is latched, because the frame in flight is not stopped:
  - frame_gen_intl → mb_ack only, abort discarded;
  - fg_arb_lost or fg_error → mb_abort_ack, no retry, no counter increment.
- Abort and mb_set in the same cycle for one mailbox: set wins, the abort is ignored.
- Retry counters are clog2(MAX_RETRY+1) bits, saturating; with MAX_RETRY=0 they never cause a fail.
- At most one bit of mb_ack/mb_fail is set per cycle; mb_abort_ack may have several bits set in one cycle.

Decomposition:
- Package can_tx_pkg holds:
  - ID_W;
  - sched_state_e {IDLE, ARB, LOAD, BUSY};
  - completion enum {CMP_NONE, CMP_OK, CMP_ERR, CMP_LOST};
  - a priority-resolve function for the completion pulses.
- Sub-module can_id_prio_sel: purely combinational; pending vector plus flattened IDs in, winner index and valid out. Lowest ID wins; ties go to the lowest index.

Test Plan:
- Single mailbox: mb_set[0] with ID 0x123 in cycle 10 → tx_start and tx_sel=0 in cycle 13; frame_gen_intl in cycle 30 → mb_ack[0] in cycle 31, tx_buff_busy low in cycle 31.
- Priority: set mb0 ID 0x200, mb1 ID 0x100, mb2 ID 0x100 together → transmission order mb1, mb2, mb0.
- Retry limit MAX_RETRY=4: mb0 sees fg_arb_lost 4 times → four tx_start pulses, then mb_fail[0] and mb_pending[0]=0; no fifth start.
- Preemption: mb0 ID 0x300 loses arbitration while mb2 ID 0x050 is set during BUSY → next tx_start has tx_sel=2.
- Abort: abort the pending non-active mb1 → mb_abort_ack[1] the next cycle. Abort the active mb0, then frame_gen_intl → mb_ack[0] only. Repeat with fg_error instead → mb_abort_ack[0] and no restart.
- Reset during BUSY: assert rst asynchronously mid-cycle → tx_buff_busy and pending flags 0 at once, no pulses; after release, IDLE with no start until the next mb_set.
